sparse_expand: RTL
==================

// Module: sparse_expand
// PURPOSE
// - Decompressor paired with the sparsity mask unit: rebuilds a dense vector of LENGTH lanes.
// - Inputs are a LENGTH-bit mask (o_mask from the mask unit) and a stream of packed non-zero values.
// - Values arrive lowest lane first, one per beat; each is placed at the next set bit of the mask.
// - Masked-off lanes are zero. Sits between the sparse buffer read port and the MAC lane array.
// PARAMETERS
// - LENGTH      32   number of lanes / mask bits
// - DATA_WIDTH  16   bits per lane value
// PORTS
// - clk           input   1                  clock
// - reset         input   1                  synchronous, active-high
// - i_mask        input   LENGTH             sparsity mask, sampled on input_ready in IDLE
// - input_ready   input   1                  mask valid; starts a transfer
// - data_valid    input   1                  packed value beat present on data_in
// - data_in       input   DATA_WIDTH         packed non-zero value
// - data_accept   output  1                  beat consumed this cycle (= state==FILL)
// - output_taken  input   1                  consumer has taken o_data; release block
// - o_data        output  LENGTH*DATA_WIDTH  dense vector; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
// - o_mask        output  LENGTH             latched mask for the current vector
// - o_count       output  $clog2(LENGTH+1)   beats consumed so far
// - state         output  2                  00 IDLE, 01 FILL, 10 DONE
// BEHAVIOUR
// - Reset: state=IDLE; o_data, o_mask, o_count and the pending mask are all 0.
// - Reset wins over every other event, including mid-FILL; partial data is discarded.
// - IDLE + input_ready:
//   - latch reg_mask=i_mask and pending=i_mask; clear o_data and o_count.
//   - next state is FILL if i_mask!=0, otherwise DONE directly with o_data all zero.
// - FILL:
//   - data_accept=1 combinationally.
//   - On data_valid, lane k = index of the lowest set bit of pending.
//   - Write o_data lane k <= data_in, clear pending[k], o_count++.
// - FILL->DONE happens in the same edge that consumes the beat where pending has exactly one bit set.
//   - state reads DONE the cycle after the last beat.
//   - Total latency is popcount(i_mask)+1 cycles from input_ready when data_valid is held high.
// - FILL with data_valid=0: hold all state; no timeout.
// - DONE: o_data, o_mask and o_count are stable. data_accept=0, so data_valid is ignored.
// - DONE + output_taken: clear o_data, o_mask, o_count and pending; next state IDLE.
// - input_ready outside IDLE is ignored; output_taken outside DONE is ignored.
// - A new transfer may start the cycle after returning to IDLE.
// - Lanes whose mask bit is 0 never get written, so they stay 0.
// - o_count never exceeds popcount(reg_mask).
// - All outputs are registered except data_accept.
// STRUCTURE
// - Shared package sparse_pkg:
//   - state typedef enum logic [1:0] {IDLE=2'b00, FILL=2'b01, DONE=2'b10}.
//   - Default LENGTH and DATA_WIDTH constants.
// - Sub-module lsb_index #(LENGTH):
//   - combinational lowest-set-bit priority encoder.
//   - outputs idx [$clog2(LENGTH)-1:0] and a one-hot output.
//   - the one-hot output is used to clear pending and as the lane write enable.
// - Last-beat detect: (pending & (pending-1)) == 0 while pending != 0.
// TESTING
// - mask=32'h0000_0005, beats 0x1111, 0x2222:
//   - lane0=0x1111, lane2=0x2222, others 0, o_count=2.
//   - DONE 3 cycles after input_ready.
// - mask=0, input_ready:
//   - DONE on the next cycle, o_data=0, o_count=0, no beats accepted.
//   - output_taken -> IDLE.
// - mask=32'hFFFF_FFFF, 32 beats with values 1..32, data_valid toggling every other cycle:
//   - lane i = i+1; state holds FILL during gaps; DONE after the 32nd beat.
// - mask=32'h8000_0001, beats 0xAAAA, 0xBBBB:
//   - lane0=0xAAAA, lane31=0xBBBB.
//   - Extra data_valid in DONE is not accepted; o_data unchanged.
// - Reset asserted after 1 of 3 beats (mask=32'h0000_0070):
//   - next cycle state=IDLE, all outputs 0.
//   - A fresh transfer then completes normally.
// - input_ready pulsed during FILL and DONE: reg_mask unchanged.
//   - output_taken pulsed during FILL: ignored.

Source files
------------

// File: rtl/sparse_pkg.sv
// Shared types and default sizing for the sparse expand datapath.
package sparse_pkg;

    localparam int unsigned LENGTH_DEF     = 32;
    localparam int unsigned DATA_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/sparse_expand_lsb_index.sv
// Combinational lowest-set-bit priority encoder: binary index plus one-hot.
module lsb_index #(
    parameter int unsigned LENGTH = 32,
    parameter int unsigned IDX_W  = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
    input  logic [LENGTH-1:0] vec_i,
    output logic [IDX_W-1:0]  idx_o,
    output logic [LENGTH-1:0] onehot_o
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot_o = vec_i & (~vec_i + LENGTH'(1));

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = int'(LENGTH) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sparse_expand.sv
// Rebuilds a dense LENGTH-lane vector from a mask and a stream of packed non-zero values.
module sparse_expand
    import sparse_pkg::*;
#(
    parameter int unsigned LENGTH     = LENGTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [LENGTH-1:0]              i_mask,
    input  logic                           input_ready,
    input  logic                           data_valid,
    input  logic [DATA_WIDTH-1:0]          data_in,
    output logic                           data_accept,
    input  logic                           output_taken,
    output logic [LENGTH*DATA_WIDTH-1:0]   o_data,
    output logic [LENGTH-1:0]              o_mask,
    output logic [$clog2(LENGTH+1)-1:0]    o_count,
    output logic [1:0]                     state
);

    localparam int unsigned IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int unsigned CNT_W = $clog2(LENGTH + 1);

    state_e                         state_q;
    logic [LENGTH*DATA_WIDTH-1:0]   data_q;
    logic [LENGTH-1:0]              mask_q;
    logic [LENGTH-1:0]              pending_q;
    logic [CNT_W-1:0]               count_q;

    logic [IDX_W-1:0]               lane_idx;
    logic [LENGTH-1:0]              lane_oh;
    logic                           last_beat;

    lsb_index #(
        .LENGTH (LENGTH),
        .IDX_W  (IDX_W)
    ) u_lsb_index (
        .vec_i    (pending_q),
        .idx_o    (lane_idx),
        .onehot_o (lane_oh)
    );

    // Exactly one lane left to fill.
    assign last_beat = (pending_q != '0) && ((pending_q & (pending_q - LENGTH'(1))) == '0);

    assign data_accept = (state_q == FILL);

    assign o_data  = data_q;
    assign o_mask  = mask_q;
    assign o_count = count_q;
    assign state   = state_q;

    // Encoder consistency: the one-hot and binary views must name the same lane.
    always_comb begin
        if (pending_q != '0) begin
            assert (lane_oh == (LENGTH'(1) << lane_idx));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            mask_q    <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (input_ready) begin
                        mask_q    <= i_mask;
                        pending_q <= i_mask;
                        data_q    <= '0;
                        count_q   <= '0;
                        state_q   <= (i_mask != '0) ? FILL : DONE;
                    end
                end
                FILL: begin
                    if (data_valid) begin
                        for (int unsigned i = 0; i < LENGTH; i++) begin
                            if (lane_oh[i]) begin
                                data_q[i*DATA_WIDTH +: DATA_WIDTH] <= data_in;
                            end
                        end
                        pending_q <= pending_q & ~lane_oh;
                        count_q   <= count_q + CNT_W'(1);
                        if (last_beat) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (output_taken) begin
                        data_q    <= '0;
                        mask_q    <= '0;
                        pending_q <= '0;
                        count_q   <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
